alu_nibble_sequencer: RTL and testbench

//  Sequences one combinational 4-bit ALU slice over NIBBLES nibbles to run N*4-bit operations.
//  One nibble is processed per clock. The carry/shift chain runs through an internal register.

---
 rtl/alu_nibble_sequencer_if.sv | 34 +++
 rtl/alu_nibble_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// Host-side start/busy/done bus of the nibble-serial ALU sequencer.
// The host drives operands and start; the sequencer returns result and flags.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   op_f;
    logic         op_com;
    logic         shift_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_carry;
    logic         flag_zero;
    logic         flag_negzero;
    logic         flag_equ;
    logic         flag_ovf;

    modport master (
        output start, op_a, op_b, op_f, op_com, shift_in,
        input  busy, done, result,
        input  flag_carry, flag_zero, flag_negzero, flag_equ, flag_ovf
    );

    modport slave (
        input  start, op_a, op_b, op_f, op_com, shift_in,
        output busy, done, result,
        output flag_carry, flag_zero, flag_negzero, flag_equ, flag_ovf
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one 4-bit ALU slice over NIBBLES nibbles, one nibble per clock.
// Define ALU_SEQ_OVF_EN to build the signed-overflow flag (else tied to 0).
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_nibble_sequencer_if.slave host,
    output logic [3:0]            slice_a,
    output logic [3:0]            slice_b,
    output logic [2:0]            slice_f,
    output logic                  slice_com,
    output logic                  slice_ci_right,
    output logic                  slice_ci_left,
    input  logic [3:0]            slice_d,
    input  logic                  slice_co_left,
    input  logic                  slice_co_right,
    input  logic                  slice_equ
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SHR = 3'd6;
    localparam logic [2:0] F_SHL = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q, b_q, res_q, res_nxt;
    logic [2:0]    f_q;
    logic          com_q, chain, chain_nxt, equ_acc;
    logic [IW-1:0] idx;
    logic          is_shr, last, carry_en;
    logic          busy_q, done_q;
    logic          carry_q, zero_q, negzero_q, equ_q;

    assign is_shr    = (f_q == F_SHR);
    assign last      = is_shr ? (idx == '0) : (idx == LAST);
    assign carry_en  = (f_q == F_ADD) || (f_q == F_SHL) || is_shr;
    assign chain_nxt = is_shr ? slice_co_right : slice_co_left;

    always_comb begin
        slice_a        = '0;
        slice_b        = '0;
        slice_f        = '0;
        slice_com      = 1'b0;
        slice_ci_right = 1'b0;
        slice_ci_left  = 1'b0;
        if (state == RUN) begin
            slice_a        = a_q[{idx, 2'b00} +: 4];
            slice_b        = b_q[{idx, 2'b00} +: 4];
            slice_f        = f_q;
            slice_com      = com_q;
            slice_ci_right = is_shr ? 1'b0 : chain;
            slice_ci_left  = is_shr ? chain : 1'b0;
        end
    end

    // Result with the current nibble merged in, so flags see the full word
    always_comb begin
        res_nxt = res_q;
        res_nxt[{idx, 2'b00} +: 4] = slice_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            f_q       <= '0;
            com_q     <= 1'b0;
            chain     <= 1'b0;
            equ_acc   <= 1'b0;
            idx       <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            negzero_q <= 1'b0;
            equ_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (host.start) begin
                        a_q     <= host.op_a;
                        b_q     <= host.op_b;
                        f_q     <= host.op_f;
                        com_q   <= host.op_com;
                        chain   <= host.shift_in;
                        equ_acc <= 1'b1;
                        idx     <= (host.op_f == F_SHR) ? LAST : '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_nxt;
                    chain   <= chain_nxt;
                    equ_acc <= equ_acc & slice_equ;
                    if (last) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        carry_q   <= carry_en & chain_nxt;
                        zero_q    <= (res_nxt == '0);
                        negzero_q <= (&res_nxt);
                        equ_q     <= equ_acc & slice_equ;
                    end else begin
                        idx <= is_shr ? idx - 1'b1 : idx + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_OVF_EN
    logic ovf_q;

    // com=0 here, so res_nxt msb is the pre-complement sum msb
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= (f_q == F_ADD) && !com_q
                  && (a_q[W-1] == b_q[W-1])
                  && (res_nxt[W-1] != a_q[W-1]);
        end
    end

    assign host.flag_ovf = ovf_q;
`else
    assign host.flag_ovf = 1'b0;
`endif

    assign host.busy         = busy_q;
    assign host.done         = done_q;
    assign host.result       = res_q;
    assign host.flag_carry   = carry_q;
    assign host.flag_zero    = zero_q;
    assign host.flag_negzero = negzero_q;
    assign host.flag_equ     = equ_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench: word-level reference model vs. the nibble-serial sequencer.
// A nibble ALU slice model closes the loop on the slice ports.
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         negzero;
        logic         equ;
        logic         ovf;
        logic [3:0]   first;
        int           edge_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] slice_a, slice_b, slice_d;
    logic [2:0] slice_f;
    logic slice_com, slice_ci_right, slice_ci_left;
    logic slice_co_left, slice_co_right, slice_equ;

    int checks = 0;
    int fails  = 0;
    int edge_cnt = 0;
    exp_t q[$];

    alu_nibble_sequencer_if #(.NIBBLES(N)) bus ();

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .host           (bus),
        .slice_a        (slice_a),
        .slice_b        (slice_b),
        .slice_f        (slice_f),
        .slice_com      (slice_com),
        .slice_ci_right (slice_ci_right),
        .slice_ci_left  (slice_ci_left),
        .slice_d        (slice_d),
        .slice_co_left  (slice_co_left),
        .slice_co_right (slice_co_right),
        .slice_equ      (slice_equ)
    );

    always #5 clk = ~clk;

    // 4-bit ALU slice: complement applies to the data output only
    always_comb begin
        logic [4:0] s;
        logic [3:0] d;
        s = '0;
        d = '0;
        slice_co_left  = 1'b0;
        slice_co_right = 1'b0;
        case (slice_f)
            3'd0: begin
                s = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_ci_right};
                d = s[3:0];
                slice_co_left = s[4];
            end
            3'd1: d = slice_a & slice_b;
            3'd2: d = slice_a | slice_b;
            3'd3: d = slice_a ^ slice_b;
            3'd4: d = slice_a;
            3'd5: d = slice_b;
            3'd6: begin
                d = {slice_ci_left, slice_a[3:1]};
                slice_co_right = slice_a[0];
            end
            default: begin
                d = {slice_a[2:0], slice_ci_right};
                slice_co_left = slice_a[3];
            end
        endcase
        slice_d   = slice_com ? ~d : d;
        slice_equ = (slice_a == slice_b);
    end

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic [2:0] f, logic com, logic si);
        exp_t e;
        logic [W:0]   sum;
        logic [W-1:0] pre;
        logic         c;
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, si};
        c   = 1'b0;
        case (f)
            3'd0: begin pre = sum[W-1:0]; c = sum[W]; end
            3'd1: pre = a & b;
            3'd2: pre = a | b;
            3'd3: pre = a ^ b;
            3'd4: pre = a;
            3'd5: pre = b;
            3'd6: begin pre = {si, a[W-1:1]}; c = a[0]; end
            default: begin pre = {a[W-2:0], si}; c = a[W-1]; end
        endcase
        e.res     = com ? ~pre : pre;
        e.carry   = c;
        e.zero    = (e.res == '0);
        e.negzero = (e.res == '1);
        e.equ     = (a == b);
`ifdef ALU_SEQ_OVF_EN
        e.ovf = (f == 3'd0) && !com && (a[W-1] == b[W-1]) && (pre[W-1] != a[W-1]);
`else
        e.ovf = 1'b0;
`endif
        e.first  = (f == 3'd6) ? a[W-1 -: 4] : a[3:0];
        e.edge_n = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side of the scoreboard: every accepted start queues its expectation
    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        if (!rst && bus.start && !bus.busy) begin
            e = model(bus.op_a, bus.op_b, bus.op_f, bus.op_com, bus.shift_in);
            e.edge_n = edge_cnt;
            q.push_back(e);
            @(negedge clk);
            if (!rst) chk("first_nibble", {28'd0, slice_a}, {28'd0, e.first});
        end
    end

    // Monitor: compare whenever the DUT presents done
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result",  {16'd0, bus.result}, {16'd0, e.res});
                chk("carry",   {31'd0, bus.flag_carry}, {31'd0, e.carry});
                chk("zero",    {31'd0, bus.flag_zero}, {31'd0, e.zero});
                chk("negzero", {31'd0, bus.flag_negzero}, {31'd0, e.negzero});
                chk("equ",     {31'd0, bus.flag_equ}, {31'd0, e.equ});
                chk("ovf",     {31'd0, bus.flag_ovf}, {31'd0, e.ovf});
                chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
                chk("latency", edge_cnt - e.edge_n, N);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(logic [W-1:0] a, logic [W-1:0] b,
                         logic [2:0] f, logic com, logic si);
        wait_idle();
        bus.op_a = a;
        bus.op_b = b;
        bus.op_f = f;
        bus.op_com = com;
        bus.shift_in = si;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.op_f = '0;
        bus.op_com = 1'b0;
        bus.shift_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("rst_done",   {31'd0, bus.done}, 32'd0);
        chk("rst_result", {16'd0, bus.result}, 32'd0);
        chk("rst_flags",  {27'd0, bus.flag_carry, bus.flag_zero, bus.flag_negzero,
                           bus.flag_equ, bus.flag_ovf}, 32'd0);
        chk("idle_slice", {16'd0, slice_a, slice_b, slice_f, slice_com,
                           slice_ci_right, slice_ci_left, 2'b00}, 32'd0);

        do_op(16'h00FF, 16'h0001, 3'd0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0);
        do_op(16'h8001, 16'h0000, 3'd7, 1'b0, 1'b1);
        do_op(16'h8001, 16'h0000, 3'd6, 1'b0, 1'b0);
        do_op(16'h1234, 16'h1234, 3'd3, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 3'd0, 1'b0, 1'b0);
        do_op(16'h0001, 16'h0001, 3'd0, 1'b0, 1'b0);

        // start pulse during RUN must be ignored
        do_op(16'h1111, 16'h2222, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        bus.op_a = 16'hAAAA;
        bus.op_f = 3'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // reset in the second RUN cycle discards the op
        do_op(16'h5555, 16'h3333, 3'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("midrst_done",   {31'd0, bus.done}, 32'd0);
        chk("midrst_result", {16'd0, bus.result}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_op(16'h0F0F, 16'h00F0, 3'd2, 1'b1, 1'b0);

        // start held through DONE is taken once more from IDLE
        wait_idle();
        bus.op_a = 16'h1357;
        bus.op_b = 16'h2468;
        bus.op_f = 3'd0;
        bus.op_com = 1'b0;
        bus.shift_in = 1'b1;
        bus.start = 1'b1;
        repeat (N + 3) @(negedge clk);
        bus.start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 4) == 0) ? a : W'($urandom);
            do_op(a, b, 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while ((q.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
